// File: rtl/counter_final_adder.sv
// Free-running up-counter; next state is a ripple-carry chain adding STEP to the count.
// Optional terminal-count flag tc is built only when COUNTER_TERMINAL_COUNT_EN is defined.
module counter_final_adder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             CLK,
  input  logic             reset,
`ifdef COUNTER_TERMINAL_COUNT_EN
  output logic             tc,
`endif
  output logic [WIDTH-1:0] out
);

  // Only the low WIDTH bits of STEP take part; higher bits wrap away.
  localparam logic [WIDTH-1:0] StepBits = WIDTH'(STEP);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_carry;

  // Full-adder cells rippling from bit 0; the last carry-out is dropped.
  always_comb begin
    w_next  = '0;
    w_carry = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_next[i] = r_count[i] ^ StepBits[i] ^ w_carry;
      w_carry   = (r_count[i] & StepBits[i]) | (w_carry & (r_count[i] ^ StepBits[i]));
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign out = r_count;

`ifdef COUNTER_TERMINAL_COUNT_EN
  assign tc = reset & (&r_count);
`endif

endmodule

// File: tb/tb_counter_final_adder.sv
// Randomized self-checking bench for counter_final_adder against a modular-arithmetic model.
// Three instances cover the default step, STEP=3, and STEP wider than WIDTH.
module tb_counter_final_adder;

  logic       CLK = 1'b0;
  logic       reset;
  logic [3:0] out0;
  logic [3:0] out1;
  logic [4:0] out2;
`ifdef COUNTER_TERMINAL_COUNT_EN
  logic       tc0, tc1, tc2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference counts
  int m0, m1, m2;

  always #5 CLK = ~CLK;

  counter_final_adder #(.WIDTH(4), .STEP(1)) u_dut0 (
    .CLK   (CLK),
    .reset (reset),
`ifdef COUNTER_TERMINAL_COUNT_EN
    .tc    (tc0),
`endif
    .out   (out0)
  );

  counter_final_adder #(.WIDTH(4), .STEP(3)) u_dut1 (
    .CLK   (CLK),
    .reset (reset),
`ifdef COUNTER_TERMINAL_COUNT_EN
    .tc    (tc1),
`endif
    .out   (out1)
  );

  counter_final_adder #(.WIDTH(5), .STEP(37)) u_dut2 (
    .CLK   (CLK),
    .reset (reset),
`ifdef COUNTER_TERMINAL_COUNT_EN
    .tc    (tc2),
`endif
    .out   (out2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive reset for one edge, update the model, then check outputs at the falling edge.
  task automatic tick(input logic rst_n);
    reset = rst_n;
`ifdef COUNTER_TERMINAL_COUNT_EN
    #1;
    check_eq("tc0_pre", {31'd0, tc0}, {31'd0, (rst_n && m0 == 15)});
    check_eq("tc1_pre", {31'd0, tc1}, {31'd0, (rst_n && m1 == 15)});
    check_eq("tc2_pre", {31'd0, tc2}, {31'd0, (rst_n && m2 == 31)});
`endif
    @(posedge CLK);
    if (!rst_n) begin
      m0 = 0;
      m1 = 0;
      m2 = 0;
    end else begin
      m0 = (m0 + 1) % 16;
      m1 = (m1 + 3) % 16;
      m2 = (m2 + 37) % 32;
    end
    @(negedge CLK);
    check_eq("out0", {28'd0, out0}, m0);
    check_eq("out1", {28'd0, out1}, m1);
    check_eq("out2", {27'd0, out2}, m2);
  endtask

  initial begin
    m0 = 0;
    m1 = 0;
    m2 = 0;
    reset = 1'b0;
    @(negedge CLK);

    // Reset held for two edges
    tick(1'b0);
    tick(1'b0);
    check_eq("rst_out0", {28'd0, out0}, 32'd0);

    // Full cycle of the default counter, including the 1111 -> 0000 wrap
    for (int i = 0; i < 16; i++) tick(1'b1);
    check_eq("wrap_out0", {28'd0, out0}, 32'd0);

    // Count to 0110, reset for one edge, then resume
    for (int i = 0; i < 6; i++) tick(1'b1);
    check_eq("mid_out0", {28'd0, out0}, 32'd6);
    tick(1'b0);
    tick(1'b1);
    check_eq("resume_out0", {28'd0, out0}, 32'd1);

    // STEP=3 directed sequence after a fresh reset
    tick(1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1);
    check_eq("step3_seq_end", {28'd0, out1}, 32'd2);

    // Reach 1111 then assert reset there
    tick(1'b0);
    for (int i = 0; i < 15; i++) tick(1'b1);
    check_eq("at_max_out0", {28'd0, out0}, 32'd15);
    tick(1'b0);

    // Randomized reset pattern, mostly counting
    for (int i = 0; i < 500; i++) begin
      tick(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
